// File: rtl/smi_self_flow_pkg.sv
// Shared definitions for the SMI SELF flow-control blocks: buffer state
// encoding and a helper for locating one branch inside a packed bus.
package smi_self_flow_pkg;

    typedef enum logic [1:0] {
        EMPTY = 2'b00,
        HALF  = 2'b01,
        FULL  = 2'b11
    } bufState_t;

    // Lowest bit index of branch 'idx' in a bus of 'width'-bit branches
    function automatic int sliceLo(input int idx, input int width);
        return idx * width;
    endfunction

endpackage

// File: rtl/smi_self_flow_skid_buffer.sv
// Two-entry registered SELF buffer. Tokens land in main first; a token that
// arrives while main is stalled is parked in skid and promoted once main
// drains. Outputs are driven from registers only.
module smi_self_flow_skid_buffer
    import smi_self_flow_pkg::*;
#(
    parameter int Width = 64
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             i_inFire,
    input  logic [Width-1:0] i_inData,
    input  logic             i_outStop,
    output logic             o_outValid,
    output logic             o_full,
    output logic [Width-1:0] o_outData
);

    bufState_t        r_state;
    bufState_t        w_nextState;
    logic [Width-1:0] r_main;
    logic [Width-1:0] r_skid;
    logic             w_outXfer;
    logic             w_loadMainFromIn;
    logic             w_loadMainFromSkid;
    logic             w_loadSkid;

    assign o_outValid = (r_state != EMPTY);
    assign o_full     = (r_state == FULL);
    assign o_outData  = r_main;
    assign w_outXfer  = o_outValid & ~i_outStop;

    // State register; reset discards any buffered tokens immediately
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state <= EMPTY;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Next state and register load selects from the incoming fire and the
    // outgoing transfer of this cycle
    always_comb begin
        w_nextState        = r_state;
        w_loadMainFromIn   = 1'b0;
        w_loadMainFromSkid = 1'b0;
        w_loadSkid         = 1'b0;
        case (r_state)
            EMPTY: begin
                if (i_inFire) begin
                    w_nextState      = HALF;
                    w_loadMainFromIn = 1'b1;
                end
            end
            HALF: begin
                if (i_inFire && w_outXfer) begin
                    w_loadMainFromIn = 1'b1;
                end else if (i_inFire) begin
                    w_nextState = FULL;
                    w_loadSkid  = 1'b1;
                end else if (w_outXfer) begin
                    w_nextState = EMPTY;
                end
            end
            FULL: begin
                if (w_outXfer) begin
                    w_nextState        = HALF;
                    w_loadMainFromSkid = 1'b1;
                end
            end
            default: begin
                w_nextState = EMPTY;
            end
        endcase
    end

    // Data registers; main takes either a fresh token or the parked one
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_main <= '0;
            r_skid <= '0;
        end else begin
            if (w_loadMainFromIn) begin
                r_main <= i_inData;
            end else if (w_loadMainFromSkid) begin
                r_main <= r_skid;
            end
            if (w_loadSkid) begin
                r_skid <= i_inData;
            end
        end
    end

endmodule

// File: rtl/smi_self_flow_join_buffer.sv
// SELF join: waits until every branch offers a token, consumes them all in
// the same cycle and forwards their concatenation through a registered
// two-entry buffer. Downstream stop never reaches the input stops
// combinationally; only the buffer's registered full flag does.
module smi_self_flow_join_buffer
    import smi_self_flow_pkg::*;
#(
    parameter int NumPorts  = 2,
    parameter int DataWidth = 32
) (
    input  logic                          clk,
    input  logic                          rstn,
    input  logic [NumPorts-1:0]           ctrlInReady,
    output logic [NumPorts-1:0]           ctrlInStop,
    input  logic [NumPorts*DataWidth-1:0] dataIn,
    output logic                          ctrlOutReady,
    input  logic                          ctrlOutStop,
    output logic [NumPorts*DataWidth-1:0] dataOut
);

    localparam int TotalWidth = NumPorts * DataWidth;

    logic                  w_allReady;
    logic                  w_bufFull;
    logic                  w_joinFire;
    logic [TotalWidth-1:0] w_joinedData;

    assign w_allReady = &ctrlInReady;
    assign w_joinFire = w_allReady & ~w_bufFull;

    // Every branch is stopped together so no branch is consumed alone
    assign ctrlInStop = {NumPorts{~w_allReady | w_bufFull}};

    // Branch i keeps its own slice in the joined word
    for (genvar gi = 0; gi < NumPorts; gi++) begin : gJoin
        assign w_joinedData[sliceLo(gi, DataWidth) +: DataWidth] =
            dataIn[sliceLo(gi, DataWidth) +: DataWidth];
    end

    smi_self_flow_skid_buffer #(
        .Width(TotalWidth)
    ) uBuffer (
        .clk        (clk),
        .rstn       (rstn),
        .i_inFire   (w_joinFire),
        .i_inData   (w_joinedData),
        .i_outStop  (ctrlOutStop),
        .o_outValid (ctrlOutReady),
        .o_full     (w_bufFull),
        .o_outData  (dataOut)
    );

endmodule

// File: tb/tb_smi_self_flow_join_buffer.sv
// Bench for the SELF join buffer with three branches. Stimulus predicts
// accepted tokens from occupancy and pushes them to a scoreboard; a
// negedge monitor pops and compares whenever the output transfers.
module tb_smi_self_flow_join_buffer;
    import smi_self_flow_pkg::*;

    localparam int NP = 3;
    localparam int DW = 32;
    localparam int W  = NP * DW;
    typedef logic [W-1:0] word_t;

    logic          clk;
    logic          rstn;
    logic [NP-1:0] ctrlInReady;
    logic [NP-1:0] ctrlInStop;
    word_t         dataIn;
    logic          ctrlOutReady;
    logic          ctrlOutStop;
    word_t         dataOut;

    smi_self_flow_join_buffer #(
        .NumPorts  (NP),
        .DataWidth (DW)
    ) dut (
        .clk          (clk),
        .rstn         (rstn),
        .ctrlInReady  (ctrlInReady),
        .ctrlInStop   (ctrlInStop),
        .dataIn       (dataIn),
        .ctrlOutReady (ctrlOutReady),
        .ctrlOutStop  (ctrlOutStop),
        .dataOut      (dataOut)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    word_t         sb[$];
    int            assertCount = 0;
    int            failCount   = 0;
    int            delivered   = 0;
    logic          expOutReady;
    logic [NP-1:0] expStop;
    logic          accepted;
    logic          holdPrev;
    word_t         prevData;

    task automatic checkOutput(input string name, input word_t actual, input word_t expected);
        assertCount++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got %h expected %h at %0t", name, actual, expected, $time);
        end
    endtask

    // One cycle of stimulus, driven just after the active edge; the model
    // decides from the buffer occupancy whether the coming edge joins
    task automatic applyStimulus(input logic rstVal, input logic [NP-1:0] rdy,
                                 input word_t data, input logic stop);
        int occ;
        @(posedge clk);
        #1;
        rstn        = rstVal;
        ctrlInReady = rdy;
        dataIn      = data;
        ctrlOutStop = stop;
        if (!rstVal) sb.delete();
        occ         = sb.size();
        expOutReady = rstVal && (occ > 0);
        expStop     = {NP{!(&rdy) || (occ == 2)}};
        accepted    = rstVal && (&rdy) && (occ < 2);
        if (accepted) sb.push_back(data);
    endtask

    function automatic word_t makeWord(input int base);
        word_t w;
        w = '0;
        for (int i = 0; i < NP; i++) w[sliceLo(i, DW) +: DW] = 32'(base + i);
        return w;
    endfunction

    // Monitor: handshake signals against the model, tokens against the scoreboard
    always @(negedge clk) begin
        checkOutput("outReady", word_t'(ctrlOutReady), word_t'(expOutReady));
        checkOutput("inStop", word_t'(ctrlInStop), word_t'(expStop));
        if (!rstn) checkOutput("resetData", dataOut, '0);
        if (holdPrev && rstn) checkOutput("stallHold", dataOut, prevData);
        if (ctrlOutReady && !ctrlOutStop) begin
            if (sb.size() == 0) begin
                checkOutput("spuriousToken", word_t'(1), word_t'(0));
            end else begin
                checkOutput("token", dataOut, sb.pop_front());
            end
            delivered++;
        end
        holdPrev = rstn && ctrlOutReady && ctrlOutStop;
        prevData = dataOut;
    end

    initial begin
        logic [NP-1:0] curRdy;
        word_t         curData;
        logic          lastAcc;
        int            startCount;

        rstn        = 1'b0;
        ctrlInReady = '1;
        dataIn      = makeWord(32'h100);
        ctrlOutStop = 1'b0;
        expOutReady = 1'b0;
        expStop     = '0;
        holdPrev    = 1'b0;
        prevData    = '0;
        accepted    = 1'b0;

        // Reset held with all branches ready, then released
        for (int i = 0; i < 3; i++) applyStimulus(1'b0, '1, makeWord(32'h100), 1'b0);
        applyStimulus(1'b1, '1, makeWord(32'h100), 1'b0);
        applyStimulus(1'b1, '0, '0, 1'b0);
        applyStimulus(1'b1, '0, '0, 1'b0);

        // Partial readiness blocks the join until every branch is ready
        for (int i = 0; i < 5; i++) applyStimulus(1'b1, 3'b001, makeWord(1), 1'b0);
        applyStimulus(1'b1, '1, makeWord(1), 1'b0);
        applyStimulus(1'b1, '0, '0, 1'b0);
        applyStimulus(1'b1, '0, '0, 1'b0);

        // Back-to-back streaming
        startCount = delivered;
        for (int i = 0; i < 16; i++) applyStimulus(1'b1, '1, makeWord(32'h1000 + 16 * i), 1'b0);
        applyStimulus(1'b1, '0, '0, 1'b0);
        applyStimulus(1'b1, '0, '0, 1'b0);
        checkOutput("streamCount", word_t'(delivered - startCount), word_t'(16));

        // Downstream stall mid-stream, then release
        for (int i = 0; i < 4; i++) applyStimulus(1'b1, '1, makeWord(32'h2000 + 16 * i), 1'b0);
        applyStimulus(1'b1, '1, makeWord(32'h3000), 1'b1);
        for (int i = 0; i < 3; i++) applyStimulus(1'b1, '1, makeWord(32'h3100), 1'b1);
        for (int i = 0; i < 4; i++) applyStimulus(1'b1, '1, makeWord(32'h3100 + 16 * i), 1'b0);
        applyStimulus(1'b1, '0, '0, 1'b0);
        applyStimulus(1'b1, '0, '0, 1'b0);

        // Fill to FULL, then reset asynchronously between edges
        applyStimulus(1'b1, '1, makeWord(32'h4000), 1'b1);
        applyStimulus(1'b1, '1, makeWord(32'h4100), 1'b1);
        applyStimulus(1'b1, '1, makeWord(32'h4200), 1'b1);
        @(posedge clk);
        #3;
        rstn = 1'b0;
        #1;
        checkOutput("asyncResetReady", word_t'(ctrlOutReady), '0);
        sb.delete();
        expOutReady = 1'b0;
        expStop     = {NP{!(&ctrlInReady)}};
        applyStimulus(1'b0, '0, '0, 1'b0);
        applyStimulus(1'b1, '0, '0, 1'b0);
        applyStimulus(1'b1, '0, '0, 1'b0);

        // Random traffic; an unconsumed ready branch holds its data
        curRdy  = '0;
        curData = '0;
        lastAcc = 1'b0;
        for (int c = 0; c < 10000; c++) begin
            for (int i = 0; i < NP; i++) begin
                if (!(curRdy[i] && !lastAcc)) begin
                    curRdy[i] = ($urandom_range(0, 3) != 0);
                    curData[sliceLo(i, DW) +: DW] = $urandom;
                end
            end
            applyStimulus(1'b1, curRdy, curData, ($urandom_range(0, 2) == 0));
            lastAcc = accepted;
        end

        // Drain and confirm nothing is left outstanding
        for (int i = 0; i < 4; i++) applyStimulus(1'b1, '0, '0, 1'b0);
        @(negedge clk);
        #1;
        checkOutput("scoreboardEmpty", word_t'(sb.size()), '0);

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule

// File: doc/smi_self_flow_join_buffer.md
# smi_self_flow_join_buffer

SELF dataflow join with a registered two-entry output buffer; the counterpart of the SELF fork controller. It merges NumPorts independent SELF input streams into one output stream. One output token is produced only when every input presents a token, and that output token is the concatenation of the input data words. The output is fully registered, so downstream stop never reaches the input stop lines combinationally. The block sits wherever forked branches reconverge in SMI datapaths.

## Interface
- NumPorts, 2: number of joined input branches (≥1).
- DataWidth, 32: data width per input branch (≥1).
- clk  input  1  clock; all state updates on rising edge.
- rstn  input  1  reset; asynchronous, active-low.
- ctrlInReady  input  NumPorts  per-branch SELF valid.
- ctrlInStop  output  NumPorts  per-branch SELF stop.
- dataIn  input  NumPorts*DataWidth  branch i occupies bits [i*DataWidth +: DataWidth].
- ctrlOutReady  output  1  output SELF valid.
- ctrlOutStop  input  1  output SELF stop.
- dataOut  output  NumPorts*DataWidth  joined word, same bit packing as dataIn.

## Operation
- SELF rule: a transfer occurs on a port in a cycle where ready=1 and stop=0. While ready=1, the data is held stable.
- allReady = &ctrlInReady. bufFull = (state==FULL). joinFire = allReady & !bufFull.
- ctrlInStop[i] = !allReady | bufFull, identical for every i. No branch is consumed unless all branches are consumed in the same cycle.
- outXfer = ctrlOutReady & !ctrlOutStop.
- Buffer state machine, two data registers (main, skid):
  - EMPTY: joinFire -> HALF, main<=dataIn.
  - HALF:
    - joinFire & outXfer -> HALF, main<=dataIn.
    - joinFire & !outXfer -> FULL, skid<=dataIn.
    - !joinFire & outXfer -> EMPTY.
    - otherwise hold.
  - FULL: joinFire is impossible.
    - outXfer -> HALF, main<=skid.
    - otherwise hold.
- ctrlOutReady = (state!=EMPTY). dataOut = main.
- Token order is preserved strictly. No token is dropped or duplicated.
- NumPorts=1 degenerates to a 2-entry SELF pipeline buffer.

## Timing
- Reset values:
  - state=EMPTY, main=0, skid=0.
  - ctrlOutReady=0, dataOut=0.
  - ctrlInStop=!allReady; all stops read 1 if any input is idle.
- Reset asserts asynchronously and may occur mid-stream. All buffered tokens are discarded. Release is synchronised externally to clk.
- Latency: an input join at edge N gives ctrlOutReady=1 from after edge N, so the token can leave at edge N+1.
- Throughput: 1 token/cycle sustained while ctrlOutStop=0.
- Downstream stall:
  - One extra token is absorbed into skid.
  - ctrlInStop goes high in the cycle after the absorbing edge and is driven from registered state only.
- Stall release (FULL & outXfer): the skid token moves to main. Inputs are re-enabled the following cycle, giving a 1-cycle bubble on the input side only.
- Input-to-input combinational path: ctrlInStop depends on ctrlInReady (inherent to join). There is no path from ctrlOutStop to ctrlInStop.

## Structure
- Shared package smi_self_flow_pkg:
  - 2-bit state encoding: EMPTY=2'b00, HALF=2'b01, FULL=2'b11.
  - Helper function for packed-slice indexing.
- Natural sub-module: smi_self_flow_skid_buffer, holding the state machine and the main/skid registers, parameterised by total width. The join top contains the AND-reduce, stop fan-out and instance only.

## Test plan
- Reset:
  - Stimulus: rstn=0 with ctrlInReady=2'b11, then release.
  - Required: ctrlOutReady=0 and dataOut=0 during reset; first edge after release with ctrlInReady=2'b11 yields ctrlOutReady=1.
- Partial readiness:
  - Stimulus: ctrlInReady=2'b01 for 5 cycles, dataIn=0x00000002_00000001.
  - Required: ctrlInStop=2'b11 throughout and no output token.
  - Stimulus: then ready=2'b11.
  - Required: one transfer; dataOut=0x00000002_00000001 next cycle.
- Streaming:
  - Stimulus: 16 joined tokens back-to-back, ctrlOutStop=0.
  - Required: 16 outputs on 16 consecutive cycles, in order, first one cycle after first join.
- Backpressure:
  - Stimulus: ctrlOutStop=1 while streaming.
  - Required: exactly one more token is accepted (state FULL), then ctrlInStop=2'b11.
  - Stimulus: release the stop.
  - Required: main token, then skid token, are delivered in order with no loss or duplication.
- Random:
  - Stimulus: 10k cycles of random per-branch ready/data and random ctrlOutStop, NumPorts=3.
  - Required: the output sequence equals the scoreboard of joined inputs, and dataOut is stable while ctrlOutReady & ctrlOutStop.
- Reset mid-stream:
  - Stimulus: assert rstn=0 asynchronously while in FULL.
  - Required: ctrlOutReady drops immediately, without waiting for an edge; after release no stale token appears.
